// File: rtl/commit_trace_aligner_pkg.sv
// Shared record types for the commit-trace aligner and its issue queue.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package commit_trace_aligner_pkg;

    // Records are sized for the widest supported core; narrower XLEN/ILEN
    // builds zero-extend on the way in and slice on the way out.
    localparam int unsigned CTA_XLEN = 64;
    localparam int unsigned CTA_ILEN = 32;

    // Identity of an issued instruction, captured in program order.
    typedef struct packed {
        logic [CTA_XLEN-1:0] pc;
        logic [CTA_ILEN-1:0] instr;
    } issue_rec_t;

    // One retired instruction as presented to the difftest commit port.
    typedef struct packed {
        logic [CTA_XLEN-1:0] pc;
        logic [CTA_ILEN-1:0] instr;
        logic                skip;
        logic                wen;
        logic [7:0]          wdest;
        logic [CTA_XLEN-1:0] wdata;
    } commit_rec_t;

    // Difftest carries an 8-bit register index; the GPR index is 5 bits.
    function automatic logic [7:0] pad_wdest(input logic [4:0] wdest);
        return {3'b000, wdest};
    endfunction

endpackage

// File: rtl/commit_trace_aligner_commit_fifo.sv
// Circular DEPTH-entry queue of issue records with push/pop/flush.
// Latency: head is combinational from storage; occupancy/flags registered.
// Backpressure: none; push while full is dropped unless a pop frees the slot.
module commit_fifo
    import commit_trace_aligner_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push_i,
    input  issue_rec_t                   push_dat_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output issue_rec_t                   head_dat_o,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned OW = $clog2(DEPTH+1);

    issue_rec_t    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic          do_push, do_pop;

    assign full_o      = (occ_q == OW'(DEPTH));
    assign empty_o     = (occ_q == '0);
    assign head_dat_o  = mem_q[rd_ptr_q];
    assign occupancy_o = occ_q;

    // A pop on a full queue frees the slot the same-cycle push lands in.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && !flush_i && (!full_o || do_pop);

    // Pointer/occupancy next state; flush wins after the pop has been taken.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage needs no reset: occupancy gates every read that matters.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/commit_trace_aligner.sv
// Merges in-order issue identity with retire writeback into one commit record.
// Latency: retire to commit_valid is 1 cycle; push visible to retire next cycle.
// Backpressure: none; overflow/underflow are dropped and flagged (sticky).
// Optional: define COMMIT_CNT_EN to add cycle_cnt/instr_cnt outputs.
module commit_trace_aligner
    import commit_trace_aligner_pkg::*;
#(
    parameter int unsigned XLEN  = 64,   // <= CTA_XLEN
    parameter int unsigned ILEN  = 32,   // <= CTA_ILEN
    parameter int unsigned DEPTH = 4     // power of two, >= 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       iss_valid,
    input  logic [XLEN-1:0]            iss_pc,
    input  logic [ILEN-1:0]            iss_instr,
    input  logic                       ret_valid,
    input  logic                       ret_skip,
    input  logic                       ret_wen,
    input  logic [4:0]                 ret_wdest,
    input  logic [XLEN-1:0]            ret_wdata,
    input  logic                       flush,
    output logic                       commit_valid,
    output logic [XLEN-1:0]            commit_pc,
    output logic [ILEN-1:0]            commit_instr,
    output logic                       commit_skip,
    output logic                       commit_wen,
    output logic [7:0]                 commit_wdest,
    output logic [XLEN-1:0]            commit_wdata,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic                       overflow_err,
    output logic                       underflow_err
`ifdef COMMIT_CNT_EN
    ,
    output logic [63:0]                cycle_cnt,
    output logic [63:0]                instr_cnt
`endif
);

    issue_rec_t  push_rec, head_rec;
    commit_rec_t commit_q, commit_d;
    logic        commit_valid_q;
    logic        overflow_q, overflow_d;
    logic        underflow_q, underflow_d;
    logic        fifo_full, fifo_empty;
    logic        ret_acc, wen_eff;

    assign push_rec.pc    = CTA_XLEN'(iss_pc);
    assign push_rec.instr = CTA_ILEN'(iss_instr);

    commit_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (iss_valid),
        .push_dat_i  (push_rec),
        .pop_i       (ret_valid),
        .flush_i     (flush),
        .head_dat_o  (head_rec),
        .occupancy_o (occupancy),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Merge head identity with retire data; x0 writes are reported as no write.
    always_comb begin
        ret_acc  = ret_valid && !fifo_empty;
        wen_eff  = ret_wen && (ret_wdest != 5'd0);
        commit_d = commit_q;
        if (ret_acc) begin
            commit_d.pc    = head_rec.pc;
            commit_d.instr = head_rec.instr;
            commit_d.skip  = ret_skip;
            commit_d.wen   = wen_eff;
            commit_d.wdest = pad_wdest(ret_wdest);
            commit_d.wdata = wen_eff ? CTA_XLEN'(ret_wdata) : '0;
        end
        // A retire on a full queue always frees a slot, and flush-cycle pushes
        // are intentionally discarded, so neither counts as overflow.
        overflow_d  = overflow_q || (iss_valid && fifo_full && !ret_valid && !flush);
        underflow_d = underflow_q || (ret_valid && fifo_empty);
    end

    // Commit record and sticky error flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            commit_q       <= '0;
            commit_valid_q <= 1'b0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            commit_q       <= commit_d;
            commit_valid_q <= ret_acc;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    assign commit_valid  = commit_valid_q;
    assign commit_pc     = commit_q.pc[XLEN-1:0];
    assign commit_instr  = commit_q.instr[ILEN-1:0];
    assign commit_skip   = commit_q.skip;
    assign commit_wen    = commit_q.wen;
    assign commit_wdest  = commit_q.wdest;
    assign commit_wdata  = commit_q.wdata[XLEN-1:0];
    assign overflow_err  = overflow_q;
    assign underflow_err = underflow_q;

`ifdef COMMIT_CNT_EN
    logic [63:0] cycle_cnt_q, instr_cnt_q;

    // Free-running cycle count and count of cycles presenting a commit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 64'd1;
            instr_cnt_q <= instr_cnt_q + {63'd0, commit_valid_q};
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_commit_trace_aligner.sv
module tb_commit_trace_aligner;

    localparam int XLEN  = 64;
    localparam int ILEN  = 32;
    localparam int DEPTH = 4;
    localparam int VW    = 1 + 64 + 32 + 1 + 1 + 8 + 64 + 3 + 1 + 1;

    logic            clk = 1'b0;
    logic            reset_n = 1'b1;
    logic            iss_valid = 1'b0;
    logic [XLEN-1:0] iss_pc = '0;
    logic [ILEN-1:0] iss_instr = '0;
    logic            ret_valid = 1'b0;
    logic            ret_skip = 1'b0;
    logic            ret_wen = 1'b0;
    logic [4:0]      ret_wdest = '0;
    logic [XLEN-1:0] ret_wdata = '0;
    logic            flush = 1'b0;

    logic            commit_valid;
    logic [XLEN-1:0] commit_pc;
    logic [ILEN-1:0] commit_instr;
    logic            commit_skip;
    logic            commit_wen;
    logic [7:0]      commit_wdest;
    logic [XLEN-1:0] commit_wdata;
    logic [2:0]      occupancy;
    logic            overflow_err;
    logic            underflow_err;
`ifdef COMMIT_CNT_EN
    logic [63:0]     cycle_cnt;
    logic [63:0]     instr_cnt;
`endif

    commit_trace_aligner #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .iss_valid     (iss_valid),
        .iss_pc        (iss_pc),
        .iss_instr     (iss_instr),
        .ret_valid     (ret_valid),
        .ret_skip      (ret_skip),
        .ret_wen       (ret_wen),
        .ret_wdest     (ret_wdest),
        .ret_wdata     (ret_wdata),
        .flush         (flush),
        .commit_valid  (commit_valid),
        .commit_pc     (commit_pc),
        .commit_instr  (commit_instr),
        .commit_skip   (commit_skip),
        .commit_wen    (commit_wen),
        .commit_wdest  (commit_wdest),
        .commit_wdata  (commit_wdata),
        .occupancy     (occupancy),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
`ifdef COMMIT_CNT_EN
        ,
        .cycle_cnt     (cycle_cnt),
        .instr_cnt     (instr_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Reference model: an in-order queue of {pc, instr} plus the last commit.
    logic [95:0] mq[$];
    logic        m_cv, m_skip, m_wen, m_ovf, m_unf;
    logic [63:0] m_pc, m_wdata, m_cycles, m_instrs;
    logic [31:0] m_instr;
    logic [7:0]  m_wdest;

    task automatic model_reset();
        mq.delete();
        m_cv = 0; m_skip = 0; m_wen = 0; m_ovf = 0; m_unf = 0;
        m_pc = '0; m_wdata = '0; m_instr = '0; m_wdest = '0;
        m_cycles = '0; m_instrs = '0;
    endtask

    function automatic logic [VW-1:0] obs_vec();
        return {commit_valid, commit_pc, commit_instr, commit_skip, commit_wen,
                commit_wdest, commit_wdata, occupancy, overflow_err, underflow_err};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {m_cv, m_pc, m_instr, m_skip, m_wen, m_wdest, m_wdata,
                3'(mq.size()), m_ovf, m_unf};
    endfunction

    // Drive one cycle of inputs, advance the model, land at posedge+1.
    task automatic do_cycle(input logic iv, input logic [63:0] pc, input logic [31:0] ins,
                            input logic rv, input logic sk, input logic we,
                            input logic [4:0] wd, input logic [63:0] wdat, input logic fl);
        logic [95:0] rec;
        iss_valid = iv; iss_pc = pc; iss_instr = ins;
        ret_valid = rv; ret_skip = sk; ret_wen = we; ret_wdest = wd; ret_wdata = wdat;
        flush = fl;
        m_cycles = m_cycles + 64'd1;
        m_instrs = m_instrs + {63'd0, m_cv};
        m_cv = 0;
        if (rv) begin
            if (mq.size() == 0) m_unf = 1;
            else begin
                rec     = mq.pop_front();
                m_cv    = 1;
                m_pc    = rec[95:32];
                m_instr = rec[31:0];
                m_skip  = sk;
                m_wen   = we && (wd != 5'd0);
                m_wdest = {3'b000, wd};
                m_wdata = m_wen ? wdat : 64'd0;
            end
        end
        if (iv && !fl) begin
            if (mq.size() < DEPTH) mq.push_back({pc, ins});
            else m_ovf = 1;
        end
        if (fl) mq.delete();
        @(posedge clk); #1;
        iss_valid = 0; ret_valid = 0; ret_skip = 0; ret_wen = 0; flush = 0;
    endtask

    task automatic idle();
        do_cycle(0, '0, '0, 0, 0, 0, '0, '0, 0);
    endtask

    task automatic push(input logic [63:0] pc, input logic [31:0] ins);
        do_cycle(1, pc, ins, 0, 0, 0, '0, '0, 0);
    endtask

    task automatic retire(input logic we, input logic [4:0] wd, input logic [63:0] wdat);
        do_cycle(0, '0, '0, 1, 0, we, wd, wdat, 0);
    endtask

    task automatic apply_reset();
        reset_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
    endtask

    task automatic test_reset();
        #1 reset_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cmp_cnt++;
        if (obs_vec() !== '0) begin
            err_cnt++;
            $display("FAIL reset_state: observed %h required 0", obs_vec());
        end
        reset_n = 1;
        idle();
        cmp_cnt++;
        if (obs_vec() !== exp_vec()) begin
            err_cnt++;
            $display("FAIL reset_idle: observed %h required %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_basic();
        push(64'h8000_0000, 32'h0010_0093);
        cmp_cnt++;
        if (occupancy !== 3'd1 || commit_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL basic_push: observed occ=%0d cv=%b required occ=1 cv=0", occupancy, commit_valid);
        end
        retire(1, 5'd1, 64'd1);
        cmp_cnt++;
        if ({commit_valid, commit_pc, commit_instr, commit_wen, commit_wdest, commit_wdata, occupancy}
            !== {1'b1, 64'h8000_0000, 32'h0010_0093, 1'b1, 8'h01, 64'd1, 3'd0}) begin
            err_cnt++;
            $display("FAIL basic_commit: observed cv=%b pc=%h in=%h wen=%b wd=%h wdat=%h occ=%0d required 1/80000000/00100093/1/01/1/0",
                     commit_valid, commit_pc, commit_instr, commit_wen, commit_wdest, commit_wdata, occupancy);
        end
        idle();
        cmp_cnt++;
        if (commit_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL basic_single_pulse: observed cv=%b required 0", commit_valid);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < DEPTH + 1; i++) push(64'h1000 + 64'(i * 4), 32'h13 + 32'(i));
        cmp_cnt++;
        if (overflow_err !== 1'b1 || occupancy !== 3'd4 || obs_vec() !== exp_vec()) begin
            err_cnt++;
            $display("FAIL overflow_flag: observed ovf=%b occ=%0d required ovf=1 occ=4", overflow_err, occupancy);
        end
        for (int i = 0; i < DEPTH; i++) begin
            retire(1, 5'd3, 64'(i));
            cmp_cnt++;
            if (commit_valid !== 1'b1 || commit_pc !== 64'h1000 + 64'(i * 4)) begin
                err_cnt++;
                $display("FAIL overflow_order[%0d]: observed cv=%b pc=%h required cv=1 pc=%h",
                         i, commit_valid, commit_pc, 64'h1000 + 64'(i * 4));
            end
        end
    endtask

    task automatic test_full_push_retire();
        apply_reset();
        for (int i = 0; i < DEPTH; i++) push(64'h2000 + 64'(i * 4), 32'h33);
        do_cycle(1, 64'h2100, 32'h6f, 1, 0, 1, 5'd7, 64'h77, 0);
        cmp_cnt++;
        if (occupancy !== 3'd4 || overflow_err !== 1'b0 || commit_pc !== 64'h2000 || obs_vec() !== exp_vec()) begin
            err_cnt++;
            $display("FAIL full_push_retire: observed occ=%0d ovf=%b pc=%h required occ=4 ovf=0 pc=2000",
                     occupancy, overflow_err, commit_pc);
        end
        for (int i = 0; i < DEPTH; i++) retire(0, 5'd0, '0);
        cmp_cnt++;
        if (commit_pc !== 64'h2100 || occupancy !== 3'd0) begin
            err_cnt++;
            $display("FAIL full_push_retire_drain: observed pc=%h occ=%0d required pc=2100 occ=0", commit_pc, occupancy);
        end
    endtask

    task automatic test_underflow();
        apply_reset();
        retire(1, 5'd2, 64'h5);
        cmp_cnt++;
        if (commit_valid !== 1'b0 || underflow_err !== 1'b1) begin
            err_cnt++;
            $display("FAIL underflow_flag: observed cv=%b unf=%b required cv=0 unf=1", commit_valid, underflow_err);
        end
        do_cycle(1, 64'h3000, 32'h93, 1, 0, 0, '0, '0, 0);
        cmp_cnt++;
        if (commit_valid !== 1'b0 || occupancy !== 3'd1) begin
            err_cnt++;
            $display("FAIL underflow_push_kept: observed cv=%b occ=%0d required cv=0 occ=1", commit_valid, occupancy);
        end
        retire(0, 5'd0, '0);
        cmp_cnt++;
        if (commit_valid !== 1'b1 || commit_pc !== 64'h3000 || obs_vec() !== exp_vec()) begin
            err_cnt++;
            $display("FAIL underflow_then_commit: observed cv=%b pc=%h required cv=1 pc=3000", commit_valid, commit_pc);
        end
    endtask

    task automatic test_wdest_zero();
        push(64'h4000, 32'h0000_0013);
        retire(1, 5'd0, 64'hdead);
        cmp_cnt++;
        if (commit_valid !== 1'b1 || commit_wen !== 1'b0 || commit_wdata !== 64'd0 || commit_wdest !== 8'h00) begin
            err_cnt++;
            $display("FAIL wdest_zero: observed cv=%b wen=%b wdata=%h wd=%h required 1/0/0/00",
                     commit_valid, commit_wen, commit_wdata, commit_wdest);
        end
        push(64'h4004, 32'h0000_0073);
        do_cycle(0, '0, '0, 1, 1, 0, 5'd9, 64'hbeef, 0);
        cmp_cnt++;
        if (commit_skip !== 1'b1 || commit_wen !== 1'b0 || commit_wdata !== 64'd0 || commit_wdest !== 8'h09) begin
            err_cnt++;
            $display("FAIL skip_nowen: observed skip=%b wen=%b wdata=%h wd=%h required 1/0/0/09",
                     commit_skip, commit_wen, commit_wdata, commit_wdest);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        push(64'hA000, 32'h1); push(64'hA004, 32'h2); push(64'hA008, 32'h3);
        do_cycle(1, 64'hA00C, 32'h4, 1, 0, 1, 5'd4, 64'h44, 1);
        cmp_cnt++;
        if (commit_valid !== 1'b1 || commit_pc !== 64'hA000 || occupancy !== 3'd0 || overflow_err !== 1'b0) begin
            err_cnt++;
            $display("FAIL flush_retire: observed cv=%b pc=%h occ=%0d ovf=%b required cv=1 pc=a000 occ=0 ovf=0",
                     commit_valid, commit_pc, occupancy, overflow_err);
        end
        retire(0, 5'd0, '0);
        cmp_cnt++;
        if (commit_valid !== 1'b0 || underflow_err !== 1'b1 || obs_vec() !== exp_vec()) begin
            err_cnt++;
            $display("FAIL flush_dropped_push: observed cv=%b unf=%b required cv=0 unf=1", commit_valid, underflow_err);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            do_cycle($urandom_range(0, 9) < 6, {$urandom, $urandom}, $urandom,
                     $urandom_range(0, 99) < 45, 1'($urandom), 1'($urandom),
                     5'($urandom), {$urandom, $urandom}, $urandom_range(0, 31) == 0);
            cmp_cnt++;
            if (obs_vec() !== exp_vec()) begin
                err_cnt++;
                $display("FAIL random[%0d]: observed %h required %h", c, obs_vec(), exp_vec());
            end
        end
    endtask

`ifdef COMMIT_CNT_EN
    task automatic test_counters();
        apply_reset();
        for (int i = 0; i < 3; i++) push(64'hC000 + 64'(i * 4), 32'h13);
        do_cycle(0, '0, '0, 1, 1, 0, '0, '0, 0);
        retire(1, 5'd5, 64'h5);
        retire(1, 5'd6, 64'h6);
        repeat (4) idle();
        cmp_cnt++;
        if (cycle_cnt !== 64'd10 || instr_cnt !== 64'd3 || cycle_cnt !== m_cycles || instr_cnt !== m_instrs) begin
            err_cnt++;
            $display("FAIL counters: observed cyc=%0d ins=%0d required cyc=10 ins=3", cycle_cnt, instr_cnt);
        end
    endtask
`endif

    task automatic test_async_reset();
        apply_reset();
        push(64'hB000, 32'h93);
        push(64'hB004, 32'h93);
        retire(1, 5'd1, 64'h11);
        cmp_cnt++;
        if (commit_valid !== 1'b1 || occupancy !== 3'd1) begin
            err_cnt++;
            $display("FAIL async_pre: observed cv=%b occ=%0d required cv=1 occ=1", commit_valid, occupancy);
        end
        #1 reset_n = 0;
        #1;
        model_reset();
        cmp_cnt++;
        if (obs_vec() !== '0) begin
            err_cnt++;
            $display("FAIL async_reset: observed %h required 0", obs_vec());
        end
`ifdef COMMIT_CNT_EN
        cmp_cnt++;
        if (cycle_cnt !== 64'd0 || instr_cnt !== 64'd0) begin
            err_cnt++;
            $display("FAIL async_reset_cnt: observed cyc=%0d ins=%0d required 0/0", cycle_cnt, instr_cnt);
        end
`endif
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        idle();
        cmp_cnt++;
        if (obs_vec() !== exp_vec()) begin
            err_cnt++;
            $display("FAIL async_release: observed %h required %h", obs_vec(), exp_vec());
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_retire();
        test_underflow();
        test_wdest_zero();
        test_flush();
        test_random();
`ifdef COMMIT_CNT_EN
        test_counters();
`endif
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
